// File: rtl/seq_divider_32by16.sv
// ---------------------------------------------------------------------------
// seq_divider_32by16 : unsigned restoring divider, one quotient bit per clock
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider_32by16 #(
  parameter int DW = 32,
  parameter int VW = 16,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZDIV = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_last;

  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_div;
  logic [VW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_remo;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;

  logic [VW:0]   w_trial;
  logic          w_ge;
  logic [VW-1:0] w_rem_nxt;
  logic [DW-1:0] w_dvd_nxt;

  // r_dvd shifts left: dividend bits leave at the top, quotient bits enter at the bottom
  assign w_trial   = {r_rem, r_dvd[DW-1]};
  assign w_ge      = (w_trial >= {1'b0, r_div});
  assign w_rem_nxt = w_ge ? VW'(w_trial - {1'b0, r_div}) : w_trial[VW-1:0];
  assign w_dvd_nxt = {r_dvd[DW-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (divisor == '0) ? S_ZDIV : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(DW - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ZDIV:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dvd  <= dividend;
        r_div  <= divisor;
        r_rem  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
        if (divisor != '0) begin
          r_dbz <= 1'b0;
        end
      end else if (r_state == S_RUN) begin
        r_dvd <= w_dvd_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_quot <= w_dvd_nxt;
          r_remo <= w_rem_nxt;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end else if (r_state == S_ZDIV) begin
        // Divide by zero saturates the quotient and passes the low dividend bits through
        r_quot <= '1;
        r_remo <= r_dvd[VW-1:0];
        r_dbz  <= 1'b1;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign dbz       = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_32by16.sv
// Bench for seq_divider_32by16: directed literal cases, handshake/reset cases,
// and a random sweep compared cycle by cycle against an arithmetic model.
`default_nettype none

module tb_seq_divider_32by16;

  localparam int DW = 32;
  localparam int VW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider_32by16 #(.DW(DW), .VW(VW), .CW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request is accepted when idle, its result is
  // computed with plain / and %, and it appears after a fixed latency.
  logic          m_busy;
  logic          m_done;
  logic [DW-1:0] m_q;
  logic [VW-1:0] m_r;
  logic          m_dbz;
  int            m_cnt;
  logic [DW-1:0] p_q;
  logic [VW-1:0] p_r;
  logic          p_dbz;
  logic [DW-1:0] p_a;
  logic [VW-1:0] p_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_dbz  <= p_dbz;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        p_a    <= dividend;
        p_b    <= divisor;
        if (divisor == '0) begin
          m_cnt <= 1;
          p_q   <= '1;
          p_r   <= dividend[VW-1:0];
          p_dbz <= 1'b1;
        end else begin
          m_cnt <= DW;
          p_q   <= dividend / DW'(divisor);
          p_r   <= VW'(dividend % DW'(divisor));
          p_dbz <= 1'b0;
          m_dbz <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("dbz", dbz, m_dbz);
      if (done && !dbz) begin
        check("invariant", 64'(quotient) * 64'(divisor_of_result()) + 64'(remainder), 64'(p_a));
        check("rem_lt_div", remainder < p_b, 1'b1);
      end
    end
  end

  function automatic logic [VW-1:0] divisor_of_result();
    return p_b;
  endfunction

  // Issues one request and waits for its result; b2b issues it in the current (done) cycle.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit b2b,
                       input bit lit, input logic [DW-1:0] eq, input logic [VW-1:0] er,
                       input logic edbz);
    int n;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("op_latency", 64'(n), (b == '0) ? 64'd1 : 64'd32);
    if (lit) begin
      check("lit_quotient", quotient, eq);
      check("lit_remainder", remainder, er);
      check("lit_dbz", dbz, edbz);
    end
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 32'h0);
    check("rst_remainder", remainder, 16'h0);
    check("rst_dbz", dbz, 1'b0);
    rst_n = 1'b1;

    do_op(32'd100, 16'd7, 1'b0, 1'b1, 32'd14, 16'd2, 1'b0);
    do_op(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b1, 32'h0001_0001, 16'h0, 1'b0);
    do_op(32'hFFFF_FFFF, 16'h0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 16'h0, 1'b0);
    do_op(32'd5, 16'd9, 1'b0, 1'b1, 32'd0, 16'd5, 1'b0);
    do_op(32'd1234, 16'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 16'h04D2, 1'b1);
    do_op(32'd50, 16'd5, 1'b0, 1'b1, 32'd10, 16'd0, 1'b0);

    // A start pulse during a busy operation must be ignored.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'd1000; divisor = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd8; divisor = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("ignore_latency", 64'(n), 64'd22);
    end
    check("ignore_quotient", quotient, 32'd333);
    check("ignore_remainder", remainder, 16'd1);

    // New request issued in the done cycle.
    do_op(32'd9, 16'd3, 1'b1, 1'b1, 32'd3, 16'd0, 1'b0);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'd777; divisor = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, 32'h0);
    check("abort_remainder", remainder, 16'h0);
    check("abort_dbz", dbz, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = VW'($urandom_range(1, 15));
        4:       b = 16'hFFFF;
        default: b = VW'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) a = DW'($urandom_range(0, 70000));
      do_op(a, b, ($urandom_range(0, 1) == 1), 1'b0, '0, '0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
